// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU-op sequencer and decoder.
// Holds the ALU op encodings, MIPS opcode/funct fields, FSM states and helpers.
package alu_op_pkg;

  typedef logic [4:0] alu_op_t;

  // ALU op encodings seen by the ALU and HI/LO unit.
  localparam alu_op_t ALU_ADD     = 5'd0;
  localparam alu_op_t ALU_SUB     = 5'd1;
  localparam alu_op_t ALU_MUL     = 5'd2;
  localparam alu_op_t ALU_AND     = 5'd3;
  localparam alu_op_t ALU_OR      = 5'd4;
  localparam alu_op_t ALU_XOR     = 5'd5;
  localparam alu_op_t ALU_NOR     = 5'd6;
  localparam alu_op_t ALU_SLL     = 5'd7;
  localparam alu_op_t ALU_SRL     = 5'd8;
  localparam alu_op_t ALU_ROTR    = 5'd9;
  localparam alu_op_t ALU_SRA     = 5'd10;
  localparam alu_op_t ALU_SEH     = 5'd11;
  localparam alu_op_t ALU_ADDU    = 5'd12;
  localparam alu_op_t ALU_MULTU   = 5'd13;
  localparam alu_op_t ALU_SLT     = 5'd14;
  localparam alu_op_t ALU_SEB     = 5'd15;
  localparam alu_op_t ALU_SLTU    = 5'd16;
  localparam alu_op_t ALU_SLLV    = 5'd17;
  localparam alu_op_t ALU_SRLV    = 5'd18;
  localparam alu_op_t ALU_SRAV    = 5'd19;
  localparam alu_op_t ALU_ROTRV   = 5'd20;
  localparam alu_op_t ALU_MOV     = 5'd21;
  localparam alu_op_t ALU_LUI     = 5'd22;
  localparam alu_op_t ALU_BLTZ    = 5'd23;
  localparam alu_op_t ALU_BLEZ    = 5'd24;
  localparam alu_op_t ALU_BGTZ    = 5'd25;
  localparam alu_op_t ALU_BGEZ    = 5'd26;
  localparam alu_op_t ALU_BNE     = 5'd27;
  localparam alu_op_t ALU_INVALID = 5'b11111;

  // Primary opcodes, Instruction[31:26].
  localparam logic [5:0] OPC_SPECIAL  = 6'h00;
  localparam logic [5:0] OPC_REGIMM   = 6'h01;
  localparam logic [5:0] OPC_BEQ      = 6'h04;
  localparam logic [5:0] OPC_BNE      = 6'h05;
  localparam logic [5:0] OPC_BLEZ     = 6'h06;
  localparam logic [5:0] OPC_BGTZ     = 6'h07;
  localparam logic [5:0] OPC_ADDI     = 6'h08;
  localparam logic [5:0] OPC_ADDIU    = 6'h09;
  localparam logic [5:0] OPC_SLTI     = 6'h0A;
  localparam logic [5:0] OPC_SLTIU    = 6'h0B;
  localparam logic [5:0] OPC_ANDI     = 6'h0C;
  localparam logic [5:0] OPC_ORI      = 6'h0D;
  localparam logic [5:0] OPC_XORI     = 6'h0E;
  localparam logic [5:0] OPC_LUI      = 6'h0F;
  localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OPC_SPECIAL3 = 6'h1F;
  localparam logic [5:0] OPC_LB       = 6'h20;
  localparam logic [5:0] OPC_LH       = 6'h21;
  localparam logic [5:0] OPC_LW       = 6'h23;
  localparam logic [5:0] OPC_SB       = 6'h28;
  localparam logic [5:0] OPC_SH       = 6'h29;
  localparam logic [5:0] OPC_SW       = 6'h2B;

  // SPECIAL funct codes, Instruction[5:0].
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MOVZ  = 6'h0A;
  localparam logic [5:0] FN_MOVN  = 6'h0B;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // SPECIAL3 byte/halfword sign-extend selectors.
  localparam logic [5:0] FN_BSHFL = 6'h20;
  localparam logic [4:0] SA_SEB   = 5'h10;
  localparam logic [4:0] SA_SEH   = 5'h18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_MUL_DONE
  } state_t;

  // Multiply-class ops take the multi-cycle path.
  function automatic logic is_mul_op(alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_MULTU);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ID/EX-side bus of the ALU-op sequencer: instruction in, op and status out.
interface alu_op_sequencer_if #(
  parameter int OP_W = 5
);
  logic [31:0]     Instruction;
  logic            InstrValid;
  logic            StallIn;
  logic [OP_W-1:0] ALUOp;
  logic            ALUOpValid;
  logic            Ready;
  logic            MulBusy;
  logic            MulSigned;
  logic            HiLoWrite;

  // Pipeline front end drives instructions and the downstream hold.
  modport master (
    output Instruction, InstrValid, StallIn,
    input  ALUOp, ALUOpValid, Ready, MulBusy, MulSigned, HiLoWrite
  );

  // The sequencer itself.
  modport slave (
    input  Instruction, InstrValid, StallIn,
    output ALUOp, ALUOpValid, Ready, MulBusy, MulSigned, HiLoWrite
  );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational MIPS instruction -> ALU op decoder; also used by the hazard unit.
module alu_op_decode
  import alu_op_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     op
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_rd;

  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign unused_rd = ^instr[15:11];

  // Map opcode/funct (plus rs/rt/shamt qualifiers) onto the ALU op code.
  always_comb begin
    // NOTE: default first so every path assigns op; without it a latch is inferred.
    op = ALU_INVALID;
    case (opcode)
      OPC_SPECIAL: begin
        case (funct)
          FN_ADD:   op = ALU_ADD;
          FN_SUB:   op = ALU_SUB;
          FN_MULT:  op = ALU_MUL;
          FN_AND:   op = ALU_AND;
          FN_OR:    op = ALU_OR;
          FN_XOR:   op = ALU_XOR;
          FN_NOR:   op = ALU_NOR;
          FN_SLL:   op = ALU_SLL;
          FN_SRL: begin
            if (rs == 5'd0)      op = ALU_SRL;
            else if (rs == 5'd1) op = ALU_ROTR;
          end
          FN_SRA:   op = ALU_SRA;
          FN_ADDU:  op = ALU_ADDU;
          FN_MULTU: op = ALU_MULTU;
          FN_SLT:   op = ALU_SLT;
          FN_SLTU: begin
            if (shamt == 5'd0) op = ALU_SLTU;
          end
          FN_SLLV:  op = ALU_SLLV;
          FN_SRLV: begin
            if (shamt == 5'd0)      op = ALU_SRLV;
            else if (shamt == 5'd1) op = ALU_ROTRV;
          end
          FN_SRAV:  op = ALU_SRAV;
          FN_MOVN, FN_MOVZ, FN_MTLO, FN_MTHI: op = ALU_MOV;
          default:  op = ALU_INVALID;
        endcase
      end
      OPC_ADDI, OPC_LB, OPC_LH, OPC_LW,
      OPC_SB, OPC_SH, OPC_SW:           op = ALU_ADD;
      OPC_BEQ:                          op = ALU_SUB;
      OPC_SPECIAL2:                     op = ALU_MUL;
      OPC_ANDI:                         op = ALU_AND;
      OPC_ORI:                          op = ALU_OR;
      OPC_XORI:                         op = ALU_XOR;
      OPC_SPECIAL3: begin
        if (funct == FN_BSHFL && shamt == SA_SEH)      op = ALU_SEH;
        else if (funct == FN_BSHFL && shamt == SA_SEB) op = ALU_SEB;
      end
      OPC_ADDIU:                        op = ALU_ADDU;
      OPC_SLTI:                         op = ALU_SLT;
      OPC_SLTIU:                        op = ALU_SLTU;
      OPC_LUI:                          op = ALU_LUI;
      OPC_REGIMM: begin
        if (rt == 5'd0)      op = ALU_BLTZ;
        else if (rt == 5'd1) op = ALU_BGEZ;
      end
      OPC_BLEZ:                         op = ALU_BLEZ;
      OPC_BGTZ:                         op = ALU_BGTZ;
      OPC_BNE:                          op = ALU_BNE;
      default:                          op = ALU_INVALID;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU-op decoder with a multi-cycle sequencer for multiply-class ops.
// Stalls the front end while a multiply runs and strobes the HI/LO write at completion.
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int OP_W        = 5,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input logic              Clk,
  input logic              Rst,
  alu_op_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  alu_op_t          dec_op;
  logic             dec_mul;
  logic             dec_hilo;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hilo_pend;

  alu_op_decode u_decode (
    .instr (bus.Instruction),
    .op    (dec_op)
  );

  // Only R-type mult/multu write HI/LO; SPECIAL2 mul writes a GPR instead.
  assign dec_mul  = is_mul_op(dec_op);
  assign dec_hilo = dec_mul && (bus.Instruction[31:26] == OPC_SPECIAL);

  // FSM, latency counter and all registered outputs; StallIn freezes everything.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking throughout so every register updates from pre-edge values.
    if (Rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      hilo_pend      <= 1'b0;
      bus.ALUOp      <= '1;
      bus.ALUOpValid <= 1'b0;
      bus.Ready      <= 1'b1;
      bus.MulBusy    <= 1'b0;
      bus.MulSigned  <= 1'b0;
      bus.HiLoWrite  <= 1'b0;
    end else if (!bus.StallIn) begin
      case (state)
        // MUL_DONE accepts like IDLE, so a new instruction lands in the completion cycle.
        ST_IDLE, ST_MUL_DONE: begin
          state         <= ST_IDLE;
          bus.HiLoWrite <= 1'b0;
          if (bus.InstrValid) begin
            bus.ALUOp <= OP_W'(dec_op);
            if (dec_mul) begin
              state          <= ST_MUL_RUN;
              cnt            <= CNT_LOAD;
              hilo_pend      <= dec_hilo;
              bus.ALUOpValid <= 1'b0;
              bus.MulBusy    <= 1'b1;
              bus.Ready      <= 1'b0;
              bus.MulSigned  <= (dec_op == ALU_MUL);
            end else begin
              bus.ALUOpValid <= 1'b1;
            end
          end else begin
            bus.ALUOpValid <= 1'b0;
          end
        end
        ST_MUL_RUN: begin
          if (cnt == '0) begin
            state          <= ST_MUL_DONE;
            bus.ALUOpValid <= 1'b1;
            bus.HiLoWrite  <= hilo_pend;
            bus.MulBusy    <= 1'b0;
            bus.Ready      <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: decode table, multiply sequencing,
// stall behaviour and reset abort, on a MUL_LATENCY=4 and a MUL_LATENCY=1 instance.
module tb_alu_op_sequencer;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int hilo_cnt_a = 0;

  alu_op_sequencer_if #(.OP_W(5)) bus_a ();
  alu_op_sequencer_if #(.OP_W(5)) bus_b ();

  alu_op_sequencer #(.OP_W(5), .MUL_LATENCY(4), .CNT_W(4)) dut_a (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_a)
  );

  alu_op_sequencer #(.OP_W(5), .MUL_LATENCY(1), .CNT_W(4)) dut_b (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_b)
  );

  always #5 Clk = ~Clk;

  // Count cycles with HiLoWrite high on the long-latency instance.
  always @(negedge Clk) if (bus_a.HiLoWrite) hilo_cnt_a++;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [4:0]  op;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Step until the selected instance shows ALUOpValid, bounded by limit edges.
  task automatic wait_done(input bit sel, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel ? bus_b.ALUOpValid : bus_a.ALUOpValid) && n < limit);
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int snap;

    vecs.push_back('{"add",     enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h20), 5'd0});
    vecs.push_back('{"addi",    enc(6'h08, 5'd1, 5'd2, 5'd0, 5'd0,  6'h05), 5'd0});
    vecs.push_back('{"lb",      enc(6'h20, 5'd1, 5'd2, 5'd0, 5'd0,  6'h04), 5'd0});
    vecs.push_back('{"lw",      enc(6'h23, 5'd1, 5'd2, 5'd0, 5'd0,  6'h04), 5'd0});
    vecs.push_back('{"sw",      enc(6'h2B, 5'd1, 5'd2, 5'd0, 5'd0,  6'h08), 5'd0});
    vecs.push_back('{"sub",     enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h22), 5'd1});
    vecs.push_back('{"beq",     enc(6'h04, 5'd1, 5'd2, 5'd0, 5'd0,  6'h08), 5'd1});
    vecs.push_back('{"and",     enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h24), 5'd3});
    vecs.push_back('{"andi",    enc(6'h0C, 5'd1, 5'd2, 5'd0, 5'd0,  6'h0F), 5'd3});
    vecs.push_back('{"or",      enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h25), 5'd4});
    vecs.push_back('{"ori",     enc(6'h0D, 5'd1, 5'd2, 5'd0, 5'd0,  6'h0F), 5'd4});
    vecs.push_back('{"xor",     enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h26), 5'd5});
    vecs.push_back('{"xori",    enc(6'h0E, 5'd1, 5'd2, 5'd0, 5'd0,  6'h0F), 5'd5});
    vecs.push_back('{"nor",     enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h27), 5'd6});
    vecs.push_back('{"sll",     enc(6'h00, 5'd0, 5'd2, 5'd3, 5'd4,  6'h00), 5'd7});
    vecs.push_back('{"srl",     enc(6'h00, 5'd0, 5'd2, 5'd3, 5'd4,  6'h02), 5'd8});
    vecs.push_back('{"rotr",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd4,  6'h02), 5'd9});
    vecs.push_back('{"srl_rs2", enc(6'h00, 5'd2, 5'd2, 5'd3, 5'd4,  6'h02), 5'd31});
    vecs.push_back('{"sra",     enc(6'h00, 5'd0, 5'd2, 5'd3, 5'd4,  6'h03), 5'd10});
    vecs.push_back('{"seh",     enc(6'h1F, 5'd0, 5'd2, 5'd3, 5'h18, 6'h20), 5'd11});
    vecs.push_back('{"addu",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h21), 5'd12});
    vecs.push_back('{"addiu",   enc(6'h09, 5'd1, 5'd2, 5'd0, 5'd0,  6'h01), 5'd12});
    vecs.push_back('{"slt",     enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h2A), 5'd14});
    vecs.push_back('{"slti",    enc(6'h0A, 5'd1, 5'd2, 5'd0, 5'd0,  6'h01), 5'd14});
    vecs.push_back('{"seb",     enc(6'h1F, 5'd0, 5'd2, 5'd3, 5'h10, 6'h20), 5'd15});
    vecs.push_back('{"sltu",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h2B), 5'd16});
    vecs.push_back('{"sltu_sh", enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd3,  6'h2B), 5'd31});
    vecs.push_back('{"sltiu",   enc(6'h0B, 5'd1, 5'd2, 5'd0, 5'd0,  6'h01), 5'd16});
    vecs.push_back('{"sllv",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h04), 5'd17});
    vecs.push_back('{"srlv",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h06), 5'd18});
    vecs.push_back('{"srav",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h07), 5'd19});
    vecs.push_back('{"rotrv",   enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd1,  6'h06), 5'd20});
    vecs.push_back('{"movz",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h0A), 5'd21});
    vecs.push_back('{"movn",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h0B), 5'd21});
    vecs.push_back('{"mthi",    enc(6'h00, 5'd1, 5'd0, 5'd0, 5'd0,  6'h11), 5'd21});
    vecs.push_back('{"mtlo",    enc(6'h00, 5'd1, 5'd0, 5'd0, 5'd0,  6'h13), 5'd21});
    vecs.push_back('{"lui",     enc(6'h0F, 5'd0, 5'd2, 5'd1, 5'd2,  6'h03), 5'd22});
    vecs.push_back('{"bltz",    enc(6'h01, 5'd4, 5'd0, 5'd0, 5'd0,  6'h08), 5'd23});
    vecs.push_back('{"blez",    enc(6'h06, 5'd4, 5'd0, 5'd0, 5'd0,  6'h08), 5'd24});
    vecs.push_back('{"bgtz",    enc(6'h07, 5'd4, 5'd0, 5'd0, 5'd0,  6'h08), 5'd25});
    vecs.push_back('{"bgez",    enc(6'h01, 5'd4, 5'd1, 5'd0, 5'd0,  6'h08), 5'd26});
    vecs.push_back('{"regimm2", enc(6'h01, 5'd4, 5'd2, 5'd0, 5'd0,  6'h08), 5'd31});
    vecs.push_back('{"bne",     enc(6'h05, 5'd1, 5'd2, 5'd0, 5'd0,  6'h08), 5'd27});
    vecs.push_back('{"op3f",    enc(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0,  6'h20), 5'd31});
    vecs.push_back('{"subu",    enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0,  6'h23), 5'd31});
    vecs.push_back('{"mfhi",    enc(6'h00, 5'd0, 5'd0, 5'd3, 5'd0,  6'h10), 5'd31});

    bus_a.Instruction = '0; bus_a.InstrValid = 1'b0; bus_a.StallIn = 1'b0;
    bus_b.Instruction = '0; bus_b.InstrValid = 1'b0; bus_b.StallIn = 1'b0;

    // Reset state on both instances.
    Rst = 1'b1;
    repeat (2) tick();
    check("rst_a_op",    32'(bus_a.ALUOp), 32'h1F);
    check("rst_a_valid", 32'(bus_a.ALUOpValid), 0);
    check("rst_a_ready", 32'(bus_a.Ready), 1);
    check("rst_a_busy",  32'(bus_a.MulBusy), 0);
    check("rst_a_sign",  32'(bus_a.MulSigned), 0);
    check("rst_a_hilo",  32'(bus_a.HiLoWrite), 0);
    check("rst_b_op",    32'(bus_b.ALUOp), 32'h1F);
    check("rst_b_ready", 32'(bus_b.Ready), 1);
    Rst = 1'b0;

    // R add: registered with one cycle of latency.
    bus_a.Instruction = enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    bus_a.InstrValid  = 1'b1;
    tick();
    check("add_op",    32'(bus_a.ALUOp), 0);
    check("add_valid", 32'(bus_a.ALUOpValid), 1);
    check("add_ready", 32'(bus_a.Ready), 1);
    check("add_hilo",  32'(bus_a.HiLoWrite), 0);
    bus_a.InstrValid = 1'b0;
    tick();
    check("novalid_valid", 32'(bus_a.ALUOpValid), 0);

    // Decode table, one instruction per cycle.
    bus_a.InstrValid = 1'b1;
    foreach (vecs[i]) begin
      bus_a.Instruction = vecs[i].instr;
      tick();
      check({"dec_", vecs[i].tag}, 32'(bus_a.ALUOp), 32'(vecs[i].op));
      check({"val_", vecs[i].tag}, 32'(bus_a.ALUOpValid), 1);
    end
    bus_a.InstrValid = 1'b0;
    tick();

    // mult: four busy cycles, one HiLoWrite, add held during busy is taken at MUL_DONE.
    snap = hilo_cnt_a;
    bus_a.Instruction = enc(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18);
    bus_a.InstrValid  = 1'b1;
    tick();
    check("mult_busy0",  32'(bus_a.MulBusy), 1);
    check("mult_ready0", 32'(bus_a.Ready), 0);
    check("mult_valid0", 32'(bus_a.ALUOpValid), 0);
    check("mult_op0",    32'(bus_a.ALUOp), 2);
    check("mult_sign0",  32'(bus_a.MulSigned), 1);
    bus_a.Instruction = enc(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("mult_busy",  32'(bus_a.MulBusy), 1);
      check("mult_valid", 32'(bus_a.ALUOpValid), 0);
      check("mult_op",    32'(bus_a.ALUOp), 2);
    end
    tick();
    check("mult_done_busy",  32'(bus_a.MulBusy), 0);
    check("mult_done_hilo",  32'(bus_a.HiLoWrite), 1);
    check("mult_done_valid", 32'(bus_a.ALUOpValid), 1);
    check("mult_done_op",    32'(bus_a.ALUOp), 2);
    check("mult_done_sign",  32'(bus_a.MulSigned), 1);
    check("mult_done_ready", 32'(bus_a.Ready), 1);
    tick();
    check("after_mult_op",    32'(bus_a.ALUOp), 0);
    check("after_mult_valid", 32'(bus_a.ALUOpValid), 1);
    check("after_mult_hilo",  32'(bus_a.HiLoWrite), 0);
    bus_a.InstrValid = 1'b0;
    tick();
    check("mult_hilo_count", 32'(hilo_cnt_a - snap), 1);

    // multu with a 3-cycle stall inside MUL_RUN: completion moves out by 3 cycles.
    snap = hilo_cnt_a;
    bus_a.Instruction = enc(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h19);
    bus_a.InstrValid  = 1'b1;
    tick();
    check("multu_busy", 32'(bus_a.MulBusy), 1);
    check("multu_sign", 32'(bus_a.MulSigned), 0);
    bus_a.InstrValid = 1'b0;
    tick();
    bus_a.StallIn = 1'b1;
    repeat (3) begin
      tick();
      check("multu_stall_busy",  32'(bus_a.MulBusy), 1);
      check("multu_stall_valid", 32'(bus_a.ALUOpValid), 0);
    end
    bus_a.StallIn = 1'b0;
    wait_done(1'b0, 20, n);
    check("multu_stall_lat", 32'(n), 3);
    check("multu_done_hilo", 32'(bus_a.HiLoWrite), 1);
    check("multu_done_op",   32'(bus_a.ALUOp), 13);
    check("multu_done_sign", 32'(bus_a.MulSigned), 0);
    tick();
    check("multu_end_hilo",    32'(bus_a.HiLoWrite), 0);
    check("multu_hilo_count",  32'(hilo_cnt_a - snap), 1);

    // SPECIAL2 mul, latency 4: accept edge plus four more, no HiLoWrite.
    bus_a.Instruction = enc(6'h1C, 5'd1, 5'd2, 5'd3, 5'd0, 6'h02);
    bus_a.InstrValid  = 1'b1;
    tick();
    check("mul_a_busy", 32'(bus_a.MulBusy), 1);
    bus_a.InstrValid = 1'b0;
    wait_done(1'b0, 20, n);
    check("mul_a_lat",  32'(n), 4);
    check("mul_a_hilo", 32'(bus_a.HiLoWrite), 0);
    check("mul_a_op",   32'(bus_a.ALUOp), 2);
    tick();

    // SPECIAL2 mul, latency 1: done two cycles after accept.
    bus_b.Instruction = enc(6'h1C, 5'd1, 5'd2, 5'd3, 5'd0, 6'h02);
    bus_b.InstrValid  = 1'b1;
    tick();
    check("mul_b_busy", 32'(bus_b.MulBusy), 1);
    bus_b.InstrValid = 1'b0;
    wait_done(1'b1, 20, n);
    check("mul_b_lat",  32'(n), 1);
    check("mul_b_hilo", 32'(bus_b.HiLoWrite), 0);
    check("mul_b_busy_done", 32'(bus_b.MulBusy), 0);
    tick();

    // multu on latency 1 with StallIn during MUL_DONE: HiLoWrite is stretched.
    bus_b.Instruction = enc(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h19);
    bus_b.InstrValid  = 1'b1;
    tick();
    bus_b.InstrValid = 1'b0;
    wait_done(1'b1, 20, n);
    check("multu_b_lat",  32'(n), 1);
    check("multu_b_hilo", 32'(bus_b.HiLoWrite), 1);
    bus_b.StallIn = 1'b1;
    repeat (2) begin
      tick();
      check("stretch_hilo",  32'(bus_b.HiLoWrite), 1);
      check("stretch_valid", 32'(bus_b.ALUOpValid), 1);
    end
    bus_b.StallIn = 1'b0;
    tick();
    check("stretch_end_hilo",  32'(bus_b.HiLoWrite), 0);
    check("stretch_end_valid", 32'(bus_b.ALUOpValid), 0);

    // Reset during the 2nd MUL_RUN cycle aborts the multiply.
    snap = hilo_cnt_a;
    bus_a.Instruction = enc(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18);
    bus_a.InstrValid  = 1'b1;
    tick();
    bus_a.InstrValid = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    check("abort_op",    32'(bus_a.ALUOp), 32'h1F);
    check("abort_ready", 32'(bus_a.Ready), 1);
    check("abort_busy",  32'(bus_a.MulBusy), 0);
    check("abort_valid", 32'(bus_a.ALUOpValid), 0);
    Rst = 1'b0;
    repeat (8) tick();
    check("abort_no_hilo", 32'(hilo_cnt_a - snap), 0);
    check("abort_idle_busy", 32'(bus_a.MulBusy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Registered, multi-cycle successor to the combinational ALU-op decoder in the MIPS datapath; sits between the ID/EX pipeline register and the ALU/HI-LO unit.
- Decodes each instruction into the 5-bit ALU op and registers it (1-cycle latency).
- For multiply-class ops it sequences a parametrised multi-cycle execution and stalls the front end.
- Pulses a HI/LO write strobe when the multiply completes.

Parameters:
- OP_W, 5, ALU op width; the package encodings assume 5.
- MUL_LATENCY, 4, execute cycles for multiply-class ops; legal range 1..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MUL_LATENCY.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- Instruction  in  32  instruction word from ID.
- InstrValid  in  1  Instruction is valid this cycle.
- StallIn  in  1  downstream hold; freezes all registered outputs and the counter.
- ALUOp  out  OP_W  registered op code.
- ALUOpValid  out  1  ALUOp is valid for EX.
- Ready  out  1  block accepts a new instruction this cycle.
- MulBusy  out  1  multiply in flight; drives the IF/ID stall.
- MulSigned  out  1  1 for mult/mul, 0 for multu; held while busy.
- HiLoWrite  out  1  one-cycle strobe at mult/multu completion.

Behaviour:
- Reset values: ALUOp=5'b11111, all 1-bit outputs 0 except Ready=1. Counter=0, state=IDLE.
- Decode priority (first match wins, opcode=Instruction[31:26], funct=[5:0], shamt=[10:6], rs=[25:21], rt=[20:16]):
  - add 0: R add; addi; lb/lh/lw/sb/sh/sw
  - sub 1: R sub; beq
  - mul 2: R mult; opcode 011100
  - and 3, or 4, xor 5: R and/or/xor or andi/ori/xori
  - nor 6; sll 7 (funct 0)
  - srl 8 (funct 000010, rs=0); rotr 9 (funct 000010, rs=1); sra 10
  - seh 11 (opcode 011111, shamt 11000, funct 100000)
  - addu 12: R addu; addiu
  - multu 13
  - slt 14: R slt; slti
  - seb 15 (shamt 10000)
  - sltu 16: R sltu with shamt 0; sltiu
  - sllv 17; srlv 18 (shamt 0); srav 19; rotrv 20 (shamt 1)
  - movn/movz/mtlo/mthi 21; lui 22
  - bltz 23 (opcode 000001, rt=0); blez 24; bgtz 25; bgez 26 (rt=1); bne 27
  - anything else 31
- Multiply class: ALUOp 2 or 13. HI/LO class: the R-type subset, i.e. mult/multu. Opcode 011100 is mul to GPR and sets no HI/LO write.
- State machine IDLE / MUL_RUN / MUL_DONE. Nothing advances while StallIn=1.
- IDLE, Ready=1. On InstrValid & ~StallIn:
  - Latch ALUOp.
  - Non-multiply op: ALUOpValid=1 next cycle; stay in IDLE.
  - Multiply op: ALUOpValid=0, MulBusy=1, Ready=0; load counter=MUL_LATENCY-1; go to MUL_RUN.
  - No valid instruction: ALUOpValid=0 next cycle.
- MUL_RUN: counter decrements each unstalled cycle; at counter==0 go to MUL_DONE.
- MUL_DONE, one cycle:
  - ALUOpValid=1.
  - HiLoWrite=1 for HI/LO-class ops only.
  - MulBusy=0, Ready=1, so a new instruction is accepted in the same cycle.
  - Return to IDLE.
- Timing: with MUL_LATENCY=1, MUL_RUN lasts exactly one cycle. Total latency from acceptance to the ALUOpValid/HiLoWrite cycle is MUL_LATENCY+1 cycles.
- InstrValid while Ready=0 is ignored; upstream must hold the instruction.
- StallIn during MUL_DONE stretches HiLoWrite and ALUOpValid; the consumer samples them on the first cycle with StallIn=0.
- Rst mid-operation aborts: no HiLoWrite is emitted, and all outputs take their reset values on the next edge.

Decomposition:
- Package alu_op_pkg holds:
  - ALU op localparams ALU_ADD..ALU_BNE and ALU_INVALID=5'b11111;
  - opcode/funct constants;
  - state encoding;
  - function is_mul_op().
- One combinational sub-module, alu_op_decode (Instruction -> ALUOp), reused by the hazard unit. The sequencer wraps it with state and counter.

Test Plan:
- Reset then R add (opcode 0, funct 100000), InstrValid=1 -> next cycle ALUOp=0, ALUOpValid=1, Ready=1, HiLoWrite=0.
- Every table entry, incl. srl vs rotr (rs=0/1) and sltu with shamt≠0 -> expected code; the sltu case gives 31.
- mult with MUL_LATENCY=4 -> MulBusy=1 for 4 cycles. Then exactly one cycle with HiLoWrite=1, ALUOp=2, MulSigned=1. New add offered during busy is ignored and accepted on the MUL_DONE cycle.
- multu with StallIn=1 for 3 cycles inside MUL_RUN -> completion delayed by 3 cycles; MulSigned=0; single HiLoWrite.
- opcode 011100 (mul) -> busy sequence with ALUOpValid at end and HiLoWrite=0. Repeat with MUL_LATENCY=1 -> done 2 cycles after accept.
- Rst asserted in 2nd MUL_RUN cycle -> next cycle ALUOp=31, Ready=1, MulBusy=0, and no HiLoWrite ever seen.
